// File: rtl/hello_world_nios2_gen2_0_cpu_debug_cmd_sched.sv
// -----------------------------------------------------------------------------
// hello_world_nios2_gen2_0_cpu_debug_cmd_sched
//
// System-clock command scheduler for the Nios II JTAG debug slave. Single-cycle
// take_action strobes (plus the jdo payload) are encoded into commands, queued
// in a small FIFO and executed one at a time against the on-chip debug memory
// or the break register file. Results and status go back to the TCK half.
//
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   jdo                       debug slave payload, sampled on strobe cycles
//   take_action_ocimem_a      ADDR command  (addr <= jdo[ADDR_W+1:2])
//   take_action_ocimem_b      WRITE command (data  =  jdo[34:3])
//   take_no_action_ocimem_a   READ command
//   take_action_break_a/b/c   BRK command, select 0/1/2, data jdo[31:0]
//   err_clr                   clears the sticky monitor_error flag
//   mem_addr/read/write/wdata Avalon-style debug memory master
//   mem_rdata/waitrequest     memory read data and stall
//   break_wr/sel/wdata        one-cycle break register write
//   MonDReg                   last read data (0xDEADBEEF after a read timeout)
//   monitor_ready             FIFO empty and scheduler idle
//   monitor_error             sticky error flag
// -----------------------------------------------------------------------------
module hello_world_nios2_gen2_0_cpu_debug_cmd_sched #(
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_break_a,
    input  logic              take_action_break_b,
    input  logic              take_action_break_c,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_waitrequest,
    output logic              break_wr,
    output logic [1:0]        break_sel,
    output logic [31:0]       break_wdata,
    output logic [31:0]       MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    // BRK opcodes carry the break register select in their low two bits.
    typedef enum logic [2:0] {
        OP_ADDR  = 3'd0,
        OP_WRITE = 3'd1,
        OP_READ  = 3'd2,
        OP_BRK0  = 3'd4,
        OP_BRK1  = 3'd5,
        OP_BRK2  = 3'd6
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    op_e                fifo_op_q   [FIFO_DEPTH];
    op_e                fifo_op_d   [FIFO_DEPTH];
    logic [31:0]        fifo_data_q [FIFO_DEPTH];
    logic [31:0]        fifo_data_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    op_e                cmd_op_q, cmd_op_d;
    logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic               brk_wr_q, brk_wr_d;
    logic [1:0]         brk_sel_q, brk_sel_d;
    logic [31:0]        brk_wdata_q, brk_wdata_d;
    logic [31:0]        mon_dreg_q, mon_dreg_d;
    logic               ready_q, ready_d;
    logic               error_q, error_d;

    logic [5:0]         strobe_vec;
    logic               push_valid;
    logic               multi_strobe;
    op_e                push_op;
    logic [31:0]        push_data;
    logic               push;
    logic               pop;
    logic               err_set;
    op_e                head_op;
    logic [31:0]        head_data;
    logic               unused_jdo;

    assign unused_jdo = ^jdo[37:35];

    // Strobe encoder: the highest-priority strobe becomes the pushed command.
    // Bit 0 of strobe_vec is the highest priority; more than one bit set in a
    // cycle is an error (the losers are simply dropped).
    always_comb begin
        strobe_vec   = {take_action_break_c, take_action_break_b, take_action_break_a,
                        take_no_action_ocimem_a, take_action_ocimem_b, take_action_ocimem_a};
        push_valid   = |strobe_vec;
        multi_strobe = |(strobe_vec & (strobe_vec - 6'd1));
        push_op      = OP_ADDR;
        push_data    = 32'd0;
        if (take_action_ocimem_a) begin
            push_op   = OP_ADDR;
            push_data = 32'(jdo[ADDR_W+1:2]);
        end else if (take_action_ocimem_b) begin
            push_op   = OP_WRITE;
            push_data = jdo[34:3];
        end else if (take_no_action_ocimem_a) begin
            push_op   = OP_READ;
        end else if (take_action_break_a) begin
            push_op   = OP_BRK0;
            push_data = jdo[31:0];
        end else if (take_action_break_b) begin
            push_op   = OP_BRK1;
            push_data = jdo[31:0];
        end else if (take_action_break_c) begin
            push_op   = OP_BRK2;
            push_data = jdo[31:0];
        end
    end

    // Next-state logic for the FIFO, the scheduler FSM and every registered
    // output. Memory strobes are raised on the pop into EXEC so they are seen
    // in the same cycle as EXEC, and cleared on accept or timeout.
    always_comb begin
        state_d     = state_q;
        fifo_op_d   = fifo_op_q;
        fifo_data_d = fifo_data_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cmd_op_d    = cmd_op_q;
        cmd_addr_d  = cmd_addr_q;
        addr_d      = addr_q;
        stall_d     = stall_q;
        rdata_d     = rdata_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_wdata_d = mem_wdata_q;
        brk_wr_d    = 1'b0;
        brk_sel_d   = brk_sel_q;
        brk_wdata_d = brk_wdata_q;
        mon_dreg_d  = mon_dreg_q;
        push        = 1'b0;
        pop         = 1'b0;
        err_set     = 1'b0;
        head_op     = fifo_op_q[rd_ptr_q];
        head_data   = fifo_data_q[rd_ptr_q];

        // A push while full is always dropped, even if a pop frees a slot.
        if (push_valid) begin
            if (multi_strobe) begin
                err_set = 1'b1;
            end
            if (count_q == (PTR_W+1)'(FIFO_DEPTH)) begin
                err_set = 1'b1;
            end else begin
                push = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop        = 1'b1;
                    cmd_op_d   = head_op;
                    cmd_addr_d = head_data[ADDR_W-1:0];
                    stall_d    = '0;
                    state_d    = EXEC;
                    case (head_op)
                        OP_WRITE: begin
                            mem_write_d = 1'b1;
                            mem_wdata_d = head_data;
                        end
                        OP_READ: mem_read_d = 1'b1;
                        OP_BRK0, OP_BRK1, OP_BRK2: begin
                            brk_wr_d    = 1'b1;
                            brk_sel_d   = head_op[1:0];
                            brk_wdata_d = head_data;
                        end
                        default: ;
                    endcase
                end
            end
            EXEC: begin
                case (cmd_op_q)
                    OP_ADDR: begin
                        addr_d  = cmd_addr_q;
                        state_d = IDLE;
                    end
                    OP_READ, OP_WRITE: begin
                        if (!mem_waitrequest) begin
                            mem_read_d  = 1'b0;
                            mem_write_d = 1'b0;
                            rdata_d     = mem_rdata;
                            stall_d     = '0;
                            state_d     = DONE;
                        end else if (stall_q == CNT_W'(TIMEOUT - 1)) begin
                            // Last permitted stall cycle: abandon the access.
                            mem_read_d  = 1'b0;
                            mem_write_d = 1'b0;
                            err_set     = 1'b1;
                            stall_d     = '0;
                            if (cmd_op_q == OP_READ) begin
                                mon_dreg_d = 32'hDEADBEEF;
                            end
                            state_d = IDLE;
                        end else begin
                            stall_d = stall_q + 1'b1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
            DONE: begin
                if (cmd_op_q == OP_READ) begin
                    mon_dreg_d = rdata_q;
                end
                addr_d  = addr_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (push) begin
            fifo_op_d[wr_ptr_q]   = push_op;
            fifo_data_d[wr_ptr_q] = push_data;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

        // A new error event takes precedence over a simultaneous clear.
        error_d = err_set ? 1'b1 : (err_clr ? 1'b0 : error_q);
        ready_d = (state_d == IDLE) && (count_d == '0);
    end

    // All state, including the FIFO storage, is cleared by the async reset so
    // a reset in the middle of a command drops the memory strobes at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_op_q[i]   <= OP_ADDR;
                fifo_data_q[i] <= 32'd0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_op_q    <= OP_ADDR;
            cmd_addr_q  <= '0;
            addr_q      <= '0;
            stall_q     <= '0;
            rdata_q     <= 32'd0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= 32'd0;
            brk_wr_q    <= 1'b0;
            brk_sel_q   <= 2'd0;
            brk_wdata_q <= 32'd0;
            mon_dreg_q  <= 32'd0;
            ready_q     <= 1'b1;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            fifo_op_q   <= fifo_op_d;
            fifo_data_q <= fifo_data_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_op_q    <= cmd_op_d;
            cmd_addr_q  <= cmd_addr_d;
            addr_q      <= addr_d;
            stall_q     <= stall_d;
            rdata_q     <= rdata_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_wdata_q <= mem_wdata_d;
            brk_wr_q    <= brk_wr_d;
            brk_sel_q   <= brk_sel_d;
            brk_wdata_q <= brk_wdata_d;
            mon_dreg_q  <= mon_dreg_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
        end
    end

    assign mem_addr      = addr_q;
    assign mem_read      = mem_read_q;
    assign mem_write     = mem_write_q;
    assign mem_wdata     = mem_wdata_q;
    assign break_wr      = brk_wr_q;
    assign break_sel     = brk_sel_q;
    assign break_wdata   = brk_wdata_q;
    assign MonDReg       = mon_dreg_q;
    assign monitor_ready = ready_q;
    assign monitor_error = error_q;

endmodule

// File: tb/tb_hello_world_nios2_gen2_0_cpu_debug_cmd_sched.sv
// -----------------------------------------------------------------------------
// Testbench for hello_world_nios2_gen2_0_cpu_debug_cmd_sched.
// A memory responder and a transaction monitor surround the DUT; a command
// level model (address register, memory image, sticky error) predicts what
// every command should do once the scheduler returns to ready.
// -----------------------------------------------------------------------------
module tb_hello_world_nios2_gen2_0_cpu_debug_cmd_sched;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } mem_txn_t;

    typedef struct packed {
        logic [1:0]  sel;
        logic [31:0] data;
    } brk_txn_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic        take_action_break_a;
    logic        take_action_break_b;
    logic        take_action_break_c;
    logic        err_clr;
    logic [7:0]  mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_waitrequest;
    logic        break_wr;
    logic [1:0]  break_sel;
    logic [31:0] break_wdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    mem_txn_t    mem_q[$];
    brk_txn_t    brk_q[$];
    logic [31:0] resp_mem  [256];
    logic [31:0] model_mem [256];
    int          wait_mode = 0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = 32'd0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  model_addr;
    logic        model_err;

    localparam logic [5:0] M_ADDR  = 6'b000001;
    localparam logic [5:0] M_WRITE = 6'b000010;
    localparam logic [5:0] M_READ  = 6'b000100;
    localparam logic [5:0] M_BRKA  = 6'b001000;
    localparam logic [5:0] M_BRKB  = 6'b010000;
    localparam logic [5:0] M_BRKC  = 6'b100000;

    hello_world_nios2_gen2_0_cpu_debug_cmd_sched dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .take_action_break_a     (take_action_break_a),
        .take_action_break_b     (take_action_break_b),
        .take_action_break_c     (take_action_break_c),
        .err_clr                 (err_clr),
        .mem_addr                (mem_addr),
        .mem_read                (mem_read),
        .mem_write               (mem_write),
        .mem_wdata               (mem_wdata),
        .mem_rdata               (mem_rdata),
        .mem_waitrequest         (mem_waitrequest),
        .break_wr                (break_wr),
        .break_sel               (break_sel),
        .break_wdata             (break_wdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    // 100 MHz system clock.
    initial forever #5 clk = ~clk;

    function automatic logic [31:0] memInit(input int i);
        return (32'(i) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Memory responder: waitrequest follows wait_mode (0 low, 1 high,
    // 2 random) and read data comes from the responder's memory image.
    initial begin
        mem_waitrequest = 1'b0;
        mem_rdata       = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            case (wait_mode)
                1:       mem_waitrequest = 1'b1;
                2:       mem_waitrequest = ($urandom_range(0, 2) == 0);
                default: mem_waitrequest = 1'b0;
            endcase
            mem_rdata = ovr_en ? ovr_val : resp_mem[mem_addr];
        end
    end

    // Monitor: records every accepted memory access and every break pulse
    // cycle; accepted writes also update the responder's memory image.
    initial begin
        mem_txn_t mt;
        brk_txn_t bt;
        for (int i = 0; i < 256; i++) resp_mem[i] = memInit(i);
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if ((mem_read || mem_write) && !mem_waitrequest) begin
                    mt.wr   = mem_write;
                    mt.addr = mem_addr;
                    mt.data = mem_write ? mem_wdata : mem_rdata;
                    mem_q.push_back(mt);
                    if (mem_write) resp_mem[mem_addr] = mem_wdata;
                end
                if (break_wr) begin
                    bt.sel  = break_sel;
                    bt.data = break_wdata;
                    brk_q.push_back(bt);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic driveStrobes(input logic [5:0] mask, input logic [37:0] payload);
        jdo                     = payload;
        take_action_ocimem_a    = mask[0];
        take_action_ocimem_b    = mask[1];
        take_no_action_ocimem_a = mask[2];
        take_action_break_a     = mask[3];
        take_action_break_b     = mask[4];
        take_action_break_c     = mask[5];
    endtask

    // One strobe cycle; returns just after the edge that captured it.
    task automatic applyStimulus(input logic [5:0] mask, input logic [37:0] payload);
        @(posedge clk);
        #1;
        driveStrobes(mask, payload);
        @(posedge clk);
        #1;
        driveStrobes(6'd0, 38'd0);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!monitor_ready && n < 600);
        checkOutput(tag, 64'(monitor_ready), 64'(1));
    endtask

    task automatic clearError();
        @(posedge clk);
        #1;
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        checkOutput("err_clr", 64'(monitor_error), 64'(0));
        model_err = 1'b0;
    endtask

    // Command-level prediction, evaluated once the scheduler is ready again.
    task automatic scoreCommand(input logic [5:0] mask, input logic [37:0] payload);
        int       w;
        mem_txn_t mt;
        brk_txn_t bt;
        w = 0;
        for (int i = 5; i >= 0; i--) if (mask[i]) w = i;
        mt = '0;
        bt = '0;
        if ($countones(mask) > 1) model_err = 1'b1;
        case (w)
            0: begin
                model_addr = payload[9:2];
                checkOutput("addr_no_mem", 64'(mem_q.size()), 64'(0));
                checkOutput("addr_no_brk", 64'(brk_q.size()), 64'(0));
                checkOutput("addr_reg", 64'(mem_addr), 64'(model_addr));
            end
            1: begin
                checkOutput("wr_count", 64'(mem_q.size()), 64'(1));
                if (mem_q.size() > 0) mt = mem_q.pop_front();
                checkOutput("wr_kind", 64'(mt.wr), 64'(1));
                checkOutput("wr_addr", 64'(mt.addr), 64'(model_addr));
                checkOutput("wr_data", 64'(mt.data), 64'(payload[34:3]));
                model_mem[model_addr] = payload[34:3];
                model_addr++;
                checkOutput("wr_addr_inc", 64'(mem_addr), 64'(model_addr));
            end
            2: begin
                checkOutput("rd_count", 64'(mem_q.size()), 64'(1));
                if (mem_q.size() > 0) mt = mem_q.pop_front();
                checkOutput("rd_kind", 64'(mt.wr), 64'(0));
                checkOutput("rd_addr", 64'(mt.addr), 64'(model_addr));
                checkOutput("rd_mondreg", 64'(MonDReg), 64'(model_mem[model_addr]));
                model_addr++;
                checkOutput("rd_addr_inc", 64'(mem_addr), 64'(model_addr));
            end
            default: begin
                checkOutput("brk_count", 64'(brk_q.size()), 64'(1));
                if (brk_q.size() > 0) bt = brk_q.pop_front();
                checkOutput("brk_sel", 64'(bt.sel), 64'(w - 3));
                checkOutput("brk_data", 64'(bt.data), 64'(payload[31:0]));
                checkOutput("brk_no_mem", 64'(mem_q.size()), 64'(0));
            end
        endcase
        checkOutput("error_flag", 64'(monitor_error), 64'(model_err));
        mem_q.delete();
        brk_q.delete();
        if (model_err) clearError();
    endtask

    task automatic runCommand(input logic [5:0] mask, input logic [37:0] payload);
        applyStimulus(mask, payload);
        waitIdle("cmd_ready");
        scoreCommand(mask, payload);
    endtask

    // Main sequence: reset, directed scenarios, randomized commands, then a
    // reset in the middle of a stalled write.
    initial begin
        logic [37:0] p;
        logic [5:0]  m;
        logic [5:0]  bm [5];
        logic [37:0] bp [5];
        int          hi;
        mem_txn_t    mt;
        brk_txn_t    bt;

        reset_n = 1'b0;
        err_clr = 1'b0;
        driveStrobes(6'd0, 38'd0);
        for (int i = 0; i < 256; i++) model_mem[i] = memInit(i);
        model_addr = 8'd0;
        model_err  = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 64'(monitor_ready), 64'(1));
        checkOutput("rst_mem_read", 64'(mem_read), 64'(0));
        checkOutput("rst_mem_write", 64'(mem_write), 64'(0));
        checkOutput("rst_break_wr", 64'(break_wr), 64'(0));
        checkOutput("rst_mondreg", 64'(MonDReg), 64'(0));
        checkOutput("rst_error", 64'(monitor_error), 64'(0));
        checkOutput("rst_addr", 64'(mem_addr), 64'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // ADDR 0x10 then a zero-stall READ with cycle-exact timing.
        $display("[TB] ADDR + zero-stall READ");
        runCommand(M_ADDR, 38'(8'h10) << 2);
        ovr_en  = 1'b1;
        ovr_val = 32'h12345678;
        model_mem[8'h10] = 32'h12345678;
        applyStimulus(M_READ, 38'd0);
        @(negedge clk);
        checkOutput("t1_ready_n1", 64'(monitor_ready), 64'(0));
        checkOutput("t1_read_n1", 64'(mem_read), 64'(0));
        @(negedge clk);
        checkOutput("t1_read_n2", 64'(mem_read), 64'(1));
        checkOutput("t1_addr_n2", 64'(mem_addr), 64'(8'h10));
        @(negedge clk);
        checkOutput("t1_read_n3", 64'(mem_read), 64'(0));
        @(negedge clk);
        checkOutput("t1_mondreg_n4", 64'(MonDReg), 64'(32'h12345678));
        checkOutput("t1_addr_n4", 64'(mem_addr), 64'(8'h11));
        checkOutput("t1_ready_n4", 64'(monitor_ready), 64'(1));
        scoreCommand(M_READ, 38'd0);
        ovr_en = 1'b0;
        model_mem[8'h10] = memInit(16);

        // Writes across the address wrap, first one stalled three cycles.
        $display("[TB] WRITE wrap with stall");
        runCommand(M_ADDR, 38'(8'hFF) << 2);
        wait_mode = 1;
        p = 38'(32'hA5A5A5A5) << 3;
        applyStimulus(M_WRITE, p);
        hi = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mem_write) begin
                hi++;
                if (hi == 3) wait_mode = 0;
            end else if (hi > 0) begin
                break;
            end
        end
        checkOutput("t2_write_hold", 64'(hi), 64'(4));
        waitIdle("t2_ready");
        scoreCommand(M_WRITE, p);
        checkOutput("t2_wrap_addr", 64'(mem_addr), 64'(8'h00));
        runCommand(M_WRITE, 38'(32'h5A5A5A5A) << 3);
        checkOutput("t2_second_addr", 64'(mem_addr), 64'(8'h01));

        // Five strobes behind a stalled READ: four queue, the fifth drops.
        $display("[TB] FIFO overflow");
        runCommand(M_ADDR, 38'(8'h20) << 2);
        wait_mode = 1;
        applyStimulus(M_READ, 38'd0);
        repeat (2) @(negedge clk);
        bm[0] = M_BRKA; bm[1] = M_BRKB; bm[2] = M_BRKC; bm[3] = M_ADDR; bm[4] = M_BRKA;
        for (int i = 0; i < 5; i++) bp[i] = 38'({$urandom(), $urandom()});
        bp[3] = 38'(8'h77) << 2;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            driveStrobes(bm[i], bp[i]);
            @(posedge clk);
            #1;
        end
        driveStrobes(6'd0, 38'd0);
        @(negedge clk);
        checkOutput("t3_overflow_err", 64'(monitor_error), 64'(1));
        checkOutput("t3_busy", 64'(monitor_ready), 64'(0));
        clearError();
        wait_mode = 0;
        waitIdle("t3_drain");
        checkOutput("t3_rd_count", 64'(mem_q.size()), 64'(1));
        mt = '0;
        if (mem_q.size() > 0) mt = mem_q.pop_front();
        checkOutput("t3_rd_addr", 64'(mt.addr), 64'(8'h20));
        checkOutput("t3_mondreg", 64'(MonDReg), 64'(model_mem[8'h20]));
        checkOutput("t3_brk_count", 64'(brk_q.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            bt = '0;
            if (brk_q.size() > 0) bt = brk_q.pop_front();
            checkOutput("t3_brk_sel", 64'(bt.sel), 64'(i));
            checkOutput("t3_brk_data", 64'(bt.data), 64'(bp[i][31:0]));
        end
        checkOutput("t3_final_addr", 64'(mem_addr), 64'(8'h77));
        checkOutput("t3_no_err", 64'(monitor_error), 64'(0));
        model_addr = 8'h77;
        mem_q.delete();
        brk_q.delete();

        // Simultaneous ADDR and break_b: only ADDR runs, error flagged.
        $display("[TB] Strobe collision");
        p = 38'({$urandom(), $urandom()});
        p[9:2] = 8'h33;
        runCommand(M_ADDR | M_BRKB, p);

        // READ stuck on waitrequest times out after 255 stall cycles.
        $display("[TB] READ timeout");
        wait_mode = 1;
        applyStimulus(M_READ, 38'd0);
        hi = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (mem_read) hi++;
            else if (hi > 0) break;
        end
        checkOutput("t5_stall_len", 64'(hi), 64'(255));
        waitIdle("t5_ready");
        checkOutput("t5_mondreg", 64'(MonDReg), 64'(32'hDEADBEEF));
        checkOutput("t5_addr_kept", 64'(mem_addr), 64'(model_addr));
        checkOutput("t5_err", 64'(monitor_error), 64'(1));
        checkOutput("t5_no_accept", 64'(mem_q.size()), 64'(0));
        clearError();
        wait_mode = 0;

        // break_c with a fixed pattern.
        $display("[TB] break_c");
        runCommand(M_BRKC, 38'(32'hCAFEF00D));

        // Randomized commands, one at a time, with random stalls.
        $display("[TB] Random commands");
        wait_mode = 2;
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 4) == 0) m = 6'($urandom_range(1, 63));
            else m = 6'(1 << $urandom_range(0, 5));
            p = 38'({$urandom(), $urandom()});
            runCommand(m, p);
        end

        // Reset asserted in the middle of a stalled write with work queued.
        $display("[TB] Reset during stalled write");
        wait_mode = 1;
        runCommand(M_ADDR, 38'(8'h40) << 2);
        applyStimulus(M_WRITE, 38'({$urandom(), $urandom()}));
        applyStimulus(M_BRKA, 38'({$urandom(), $urandom()}));
        applyStimulus(M_BRKB, 38'({$urandom(), $urandom()}));
        @(negedge clk);
        checkOutput("t7_write_active", 64'(mem_write), 64'(1));
        reset_n = 1'b0;
        #1;
        checkOutput("t7_write_async", 64'(mem_write), 64'(0));
        checkOutput("t7_ready_async", 64'(monitor_ready), 64'(1));
        repeat (2) @(negedge clk);
        reset_n   = 1'b1;
        wait_mode = 0;
        model_addr = 8'd0;
        model_err  = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("t7_ready", 64'(monitor_ready), 64'(1));
        checkOutput("t7_flushed_brk", 64'(brk_q.size()), 64'(0));
        checkOutput("t7_flushed_mem", 64'(mem_q.size()), 64'(0));
        checkOutput("t7_addr", 64'(mem_addr), 64'(0));
        checkOutput("t7_err", 64'(monitor_error), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
